// File: rtl/tl_io_bridge.sv
// Bridges the single-beat TileLink io host port onto a request/grant/response
// register bus, one transaction at a time. Bad requests and bus timeouts are
// answered with denied.
module tl_io_bridge #(
  parameter int AddrWidth     = 56,
  parameter int SourceWidth   = 5,
  parameter int SinkWidth     = 1,
  parameter int TimeoutCycles = 1024
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   host_a_valid,
  output logic                   host_a_ready,
  input  logic [2:0]             host_a_opcode,
  input  logic [2:0]             host_a_param,
  input  logic [2:0]             host_a_size,
  input  logic [SourceWidth-1:0] host_a_source,
  input  logic [AddrWidth-1:0]   host_a_address,
  input  logic [7:0]             host_a_mask,
  input  logic                   host_a_corrupt,
  input  logic [63:0]            host_a_data,
  output logic                   host_d_valid,
  input  logic                   host_d_ready,
  output logic [2:0]             host_d_opcode,
  output logic [1:0]             host_d_param,
  output logic [2:0]             host_d_size,
  output logic [SourceWidth-1:0] host_d_source,
  output logic [SinkWidth-1:0]   host_d_sink,
  output logic                   host_d_denied,
  output logic                   host_d_corrupt,
  output logic [63:0]            host_d_data,
  output logic                   reg_req_o,
  input  logic                   reg_gnt_i,
  output logic                   reg_we_o,
  output logic [AddrWidth-1:0]   reg_addr_o,
  output logic [7:0]             reg_be_o,
  output logic [63:0]            reg_wdata_o,
  input  logic                   reg_rvalid_i,
  input  logic [63:0]            reg_rdata_i,
  input  logic                   reg_err_i
);

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_RESP} state_e;

  localparam logic [2:0] OP_PUT_FULL = 3'd0;
  localparam logic [2:0] OP_PUT_PART = 3'd1;
  localparam logic [2:0] OP_GET      = 3'd4;
  localparam logic [2:0] D_ACK       = 3'd0;
  localparam logic [2:0] D_ACK_DATA  = 3'd1;

  // Counter is a single unused bit when the timeout is disabled.
  localparam int            CntW    = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
  localparam logic [CntW-1:0] CntLast = (TimeoutCycles > 0) ? CntW'(TimeoutCycles - 1) : '0;
  localparam bit            TmoEn   = (TimeoutCycles > 0);

  state_e r_state, w_next;

  logic [2:0]             r_opcode;
  logic [2:0]             r_size;
  logic [SourceWidth-1:0] r_source;
  logic [AddrWidth-1:0]   r_addr;
  logic [7:0]             r_mask;
  logic [63:0]            r_wdata;
  logic [63:0]            r_rdata;
  logic                   r_denied;
  logic                   r_we;
  logic [CntW-1:0]        r_cnt;

  logic w_a_fire, w_d_fire, w_align_ok, w_op_ok, w_legal, w_timeout;

  assign w_a_fire = host_a_valid & host_a_ready;
  assign w_d_fire = host_d_valid & host_d_ready;

  always_comb begin
    w_align_ok = 1'b0;
    case (host_a_size)
      3'd0:    w_align_ok = 1'b1;
      3'd1:    w_align_ok = ~host_a_address[0];
      3'd2:    w_align_ok = (host_a_address[1:0] == 2'b00);
      3'd3:    w_align_ok = (host_a_address[2:0] == 3'b000);
      default: w_align_ok = 1'b0;
    endcase
  end

  assign w_op_ok   = (host_a_opcode == OP_GET) || (host_a_opcode == OP_PUT_FULL) ||
                     (host_a_opcode == OP_PUT_PART);
  // Oversized requests already fail w_align_ok via its default arm.
  assign w_legal   = w_op_ok & w_align_ok & ~host_a_corrupt;
  assign w_timeout = TmoEn && (r_cnt == CntLast);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= ST_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_a_fire) w_next = w_legal ? ST_REQ : ST_RESP;
      ST_REQ:  if (reg_gnt_i) w_next = ST_WAIT;
      ST_WAIT: if (reg_rvalid_i || w_timeout) w_next = ST_RESP;
      ST_RESP: if (w_d_fire) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_opcode <= '0;
      r_size   <= '0;
      r_source <= '0;
      r_addr   <= '0;
      r_mask   <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
      r_denied <= 1'b0;
      r_we     <= 1'b0;
      r_cnt    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: if (w_a_fire) begin
          r_opcode <= host_a_opcode;
          r_size   <= host_a_size;
          r_source <= host_a_source;
          r_addr   <= host_a_address;
          r_mask   <= host_a_mask;
          r_wdata  <= host_a_data;
          r_rdata  <= '0;
          r_denied <= ~w_legal;
          r_we     <= w_legal & (host_a_opcode != OP_GET);
          r_cnt    <= '0;
        end
        ST_REQ: if (reg_gnt_i) r_cnt <= '0;
        ST_WAIT: begin
          // Response wins over a timeout landing in the same cycle.
          if (reg_rvalid_i) begin
            r_denied <= reg_err_i;
            if ((r_opcode == OP_GET) && !reg_err_i) r_rdata <= reg_rdata_i;
          end else if (w_timeout) begin
            r_denied <= 1'b1;
          end
          if (r_cnt != '1) r_cnt <= r_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign host_a_ready   = (r_state == ST_IDLE);
  assign reg_req_o      = (r_state == ST_REQ);
  assign reg_we_o       = r_we;
  assign reg_addr_o     = r_addr;
  assign reg_be_o       = r_mask;
  assign reg_wdata_o    = r_wdata;

  assign host_d_valid   = (r_state == ST_RESP);
  assign host_d_opcode  = (r_opcode == OP_GET) ? D_ACK_DATA : D_ACK;
  assign host_d_param   = 2'd0;
  assign host_d_size    = r_size;
  assign host_d_source  = r_source;
  assign host_d_sink    = '0;
  assign host_d_denied  = r_denied;
  assign host_d_corrupt = r_denied & (r_opcode == OP_GET);
  assign host_d_data    = r_rdata;

  logic w_unused;
  assign w_unused = ^host_a_param;

endmodule
